// File: rtl/i2s_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_transmitter_if
// Brief    : Sample-in / I2S-out bundle between the NCO, the transmitter and
//            the external DAC. I2S_STEREO_EN adds the right-channel input.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_transmitter_if #(
  parameter int SAMPLE_W = 16
);
  logic signed [SAMPLE_W-1:0] sample_in;
`ifdef I2S_STEREO_EN
  logic signed [SAMPLE_W-1:0] sample_in_r;
`endif
  logic                       sample_en;
  logic                       bclk;
  logic                       lrclk;
  logic                       sdata;

`ifdef I2S_STEREO_EN
  modport master (
    input  sample_in, sample_in_r,
    output sample_en, bclk, lrclk, sdata
  );
  modport slave (
    output sample_in, sample_in_r,
    input  sample_en, bclk, lrclk, sdata
  );
`else
  modport master (
    input  sample_in,
    output sample_en, bclk, lrclk, sdata
  );
  modport slave (
    output sample_in,
    input  sample_en, bclk, lrclk, sdata
  );
`endif
endinterface
`default_nettype wire

// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : i2s_transmitter
// Brief    : Serialises held NCO samples into a 64-BCLK I2S frame and paces
//            the NCO with one sample_en pulse per frame.
//            Define I2S_STEREO_EN for a separate right-channel input.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_transmitter #(
  parameter int BCLK_HALF_DIV = 2,
  parameter int SAMPLE_W      = 16
) (
  input  wire logic         master_clk,
  input  wire logic         rst,
  i2s_transmitter_if.master bus
);

  localparam int              DIV_W       = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_tc   = DIV_W'(BCLK_HALF_DIV - 1);
  localparam logic [4:0]      c_slot_bits = 5'(SAMPLE_W);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic [5:0]          pos_q, pos_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                sample_en_q, sample_en_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;

  logic                div_tc;
  logic                bclk_fall;
  logic                boundary;
  logic [4:0]          slot_off;
  logic [SAMPLE_W-1:0] slot_word;
  logic [SAMPLE_W-1:0] slot_shift;
  logic                slot_bit;
  logic [SAMPLE_W-1:0] right_src;

`ifdef I2S_STEREO_EN
  assign right_src = bus.sample_in_r;
`else
  assign right_src = bus.sample_in;
`endif

  always_comb begin
    div_tc      = (div_cnt_q == c_div_tc);
    bclk_fall   = div_tc & bclk_q;
    boundary    = bclk_fall & (pos_q == 6'd63);

    div_cnt_d   = div_tc ? '0 : div_cnt_q + 1'b1;
    bclk_d      = bclk_q ^ div_tc;
    pos_d       = pos_q + {5'd0, bclk_fall};
    lrclk_d     = bclk_fall ? pos_d[5] : lrclk_q;

    hold_l_d    = boundary ? bus.sample_in : hold_l_q;
    hold_r_d    = boundary ? right_src     : hold_r_q;
    sample_en_d = boundary;

    // Slot offset 1..SAMPLE_W carries MSB..LSB; offset 0 is the one-BCLK I2S delay.
    slot_off    = pos_d[4:0];
    slot_word   = pos_d[5] ? hold_r_q : hold_l_q;
    slot_shift  = slot_word >> (c_slot_bits - slot_off);
    slot_bit    = (slot_off != 5'd0) && (slot_off <= c_slot_bits) && slot_shift[0];
    sdata_d     = bclk_fall ? slot_bit : sdata_q;
  end

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      pos_q       <= 6'd0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      sample_en_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      pos_q       <= pos_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      sample_en_q <= sample_en_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
    end
  end

  assign bus.bclk      = bclk_q;
  assign bus.lrclk     = lrclk_q;
  assign bus.sdata     = sdata_q;
  assign bus.sample_en = sample_en_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_transmitter
// Brief    : Directed frame-level bench for i2s_transmitter at BCLK_HALF_DIV
//            of 2 and 1; stereo vectors apply when I2S_STEREO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_transmitter;

  localparam int SW = 16;

  logic master_clk = 1'b0;
  logic rst        = 1'b0;
  int   cyc        = 0;
  int   n_checks   = 0;
  int   n_errors   = 0;

  always #5 master_clk = ~master_clk;

  i2s_transmitter_if #(.SAMPLE_W(SW)) bus2 ();
  i2s_transmitter_if #(.SAMPLE_W(SW)) bus1 ();

  i2s_transmitter #(.BCLK_HALF_DIV(2), .SAMPLE_W(SW)) dut2 (
    .master_clk (master_clk),
    .rst        (rst),
    .bus        (bus2)
  );

  i2s_transmitter #(.BCLK_HALF_DIV(1), .SAMPLE_W(SW)) dut1 (
    .master_clk (master_clk),
    .rst        (rst),
    .bus        (bus1)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // {bclk, lrclk, sdata, sample_en}
  function automatic logic [3:0] outs(input int sel);
    if (sel == 1) return {bus1.bclk, bus1.lrclk, bus1.sdata, bus1.sample_en};
    return {bus2.bclk, bus2.lrclk, bus2.sdata, bus2.sample_en};
  endfunction

  task automatic step();
    @(posedge master_clk);
    #1;
    cyc++;
  endtask

  task automatic release_rst();
    @(negedge master_clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          pad_ones;
    int          lr_err;
    int          gap_err;
    int          se_cnt;
    int          se_cyc;
    int          first_rise;
    int          first_fall;
  } frame_t;

  // Follows nfalls BCLK falling edges from a frame start (pos 0).
  task automatic run_frame(input int sel, input int nfalls, output frame_t f);
    logic [3:0] o;
    logic       prev_b;
    int         pos, falls, last_fall, budget, half;
    half = (sel == 1) ? 1 : 2;
    f = '{l: 16'h0, r: 16'h0, pad_ones: 0, lr_err: 0, gap_err: 0,
          se_cnt: 0, se_cyc: -1, first_rise: -1, first_fall: -1};
    o = outs(sel);
    prev_b = o[3];
    pos = 0; falls = 0; last_fall = -1; budget = 0;
    while (falls < nfalls && budget < 1000) begin
      step();
      budget++;
      o = outs(sel);
      if (o[0]) begin
        f.se_cnt++;
        f.se_cyc = cyc;
      end
      if (!prev_b && o[3] && f.first_rise < 0) f.first_rise = cyc;
      if (prev_b && !o[3]) begin
        falls++;
        pos = (pos + 1) % 64;
        if (f.first_fall < 0) f.first_fall = cyc;
        if (last_fall >= 0 && (cyc - last_fall) != 2 * half) f.gap_err++;
        last_fall = cyc;
        if (o[2] !== (pos >= 32)) f.lr_err++;
        if (pos >= 1 && pos <= 16)       f.l = {f.l[14:0], o[1]};
        else if (pos >= 33 && pos <= 48) f.r = {f.r[14:0], o[1]};
        else                             f.pad_ones += int'(o[1]);
      end
      prev_b = o[3];
    end
    check("frame_falls", falls, nfalls);
  endtask

  frame_t f;

  initial begin
    bus2.sample_in = 16'hA5C3;
    bus1.sample_in = 16'h0001;
`ifdef I2S_STEREO_EN
    bus2.sample_in_r = 16'hA5C3;
    bus1.sample_in_r = 16'h0001;
`endif
    repeat (3) @(posedge master_clk);
    #1;
    check("rst_outs_d2", int'(outs(0)), 0);
    check("rst_outs_d1", int'(outs(1)), 0);

    release_rst();
    run_frame(0, 64, f);
    check("f0_first_rise", f.first_rise, 2);
    check("f0_first_fall", f.first_fall, 4);
    check("f0_left_zero", int'(f.l), 0);
    check("f0_right_zero", int'(f.r), 0);
    check("f0_pad", f.pad_ones, 0);
    check("f0_gap", f.gap_err, 0);
    check("f0_se_cyc", f.se_cyc, 256);
    check("f0_se_cnt", f.se_cnt, 1);

    run_frame(0, 64, f);
    check("f1_left", int'(f.l), 16'hA5C3);
    check("f1_right", int'(f.r), 16'hA5C3);
    check("f1_pad", f.pad_ones, 0);
    check("f1_lrclk", f.lr_err, 0);
    check("f1_se_cyc", f.se_cyc, 512);
    check("f1_se_cnt", f.se_cnt, 1);

    // Changed while sample_en is high: the value already captured is kept.
    bus2.sample_in = 16'h8000;
    run_frame(0, 64, f);
    check("f2_left_old", int'(f.l), 16'hA5C3);
    check("f2_se_cyc", f.se_cyc, 768);

    step();
    bus2.sample_in = 16'h7FFF;
    run_frame(0, 64, f);
    check("f3_left", int'(f.l), 16'h8000);
    check("f3_right", int'(f.r), 16'h8000);
    check("f3_se_cyc", f.se_cyc, 1024);
    run_frame(0, 64, f);
    check("f4_left", int'(f.l), 16'h7FFF);
    check("f4_right", int'(f.r), 16'h7FFF);
    check("f4_pad", f.pad_ones, 0);

    // Reset mid-frame at pos 20 while bclk is high.
    run_frame(0, 20, f);
    step();
    step();
    check("pre_rst_bclk", int'(outs(0)), 4'b1000);
    rst = 1'b0;
    #1;
    check("async_rst_outs", int'(outs(0)), 0);
    release_rst();
    run_frame(0, 64, f);
    check("r0_first_rise", f.first_rise, 2);
    check("r0_first_fall", f.first_fall, 4);
    check("r0_left_zero", int'(f.l), 0);
    check("r0_right_zero", int'(f.r), 0);
    check("r0_se_cyc", f.se_cyc, 256);
    run_frame(0, 64, f);
    check("r1_left", int'(f.l), 16'h7FFF);
    check("r1_se_cyc", f.se_cyc, 512);

    // BCLK_HALF_DIV = 1 instance from a fresh reset.
    rst = 1'b0;
    #1;
    release_rst();
    run_frame(1, 64, f);
    check("d1_first_rise", f.first_rise, 1);
    check("d1_first_fall", f.first_fall, 2);
    check("d1_gap0", f.gap_err, 0);
    check("d1_se_cyc0", f.se_cyc, 128);
    check("d1_left_zero", int'(f.l), 0);
    run_frame(1, 64, f);
    check("d1_left", int'(f.l), 16'h0001);
    check("d1_right", int'(f.r), 16'h0001);
    check("d1_pad", f.pad_ones, 0);
    check("d1_lrclk", f.lr_err, 0);
    check("d1_gap1", f.gap_err, 0);
    check("d1_se_cyc1", f.se_cyc, 256);

`ifdef I2S_STEREO_EN
    rst = 1'b0;
    #1;
    bus2.sample_in   = 16'h1234;
    bus2.sample_in_r = 16'hFEDC;
    release_rst();
    run_frame(0, 64, f);
    run_frame(0, 64, f);
    check("st_left", int'(f.l), 16'h1234);
    check("st_right", int'(f.r), 16'hFEDC);
    check("st_pad", f.pad_ones, 0);
    check("st_lrclk", f.lr_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
